// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port between the processor
// writeback stage and NUM_REQ external writers. The processor always wins.
// Each writer has a one-entry holding buffer and a ready/ack handshake.
// Pending buffers are served round-robin, and long waits raise o_starve.
// i_reset is asynchronous and active-low.
module regfile_write_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_cpu_we,
  input  logic [4:0]              i_cpu_waddr,
  input  logic [31:0]             i_cpu_wdata,
  input  logic [NUM_REQ-1:0]      i_ext_req,
  input  logic [5*NUM_REQ-1:0]    i_ext_addr,
  input  logic [32*NUM_REQ-1:0]   i_ext_data,
  output logic [NUM_REQ-1:0]      o_ext_ready,
  output logic [NUM_REQ-1:0]      o_ext_ack,
  output logic [NUM_REQ-1:0]      o_ext_overflow,
  output logic                    o_rf_we,
  output logic [4:0]              o_rf_waddr,
  output logic [31:0]             o_rf_wdata,
  output logic [2:0]              o_rf_src,
  output logic                    o_starve
);

  // Index width for 2..4 writers; one extra bit holds last+k before wrapping.
  localparam int            IW   = (NUM_REQ > 2) ? 2 : 1;
  localparam int            CW   = IW + 1;
  localparam logic [CW-1:0] NR_C = CW'(NUM_REQ);
  localparam logic [7:0]    SL_C = 8'(STARVE_LIMIT);

  logic [NUM_REQ-1:0] r_pend;
  logic [NUM_REQ-1:0] r_ack;
  logic [NUM_REQ-1:0] r_ovf;
  logic [4:0]         r_addr_q [NUM_REQ];
  logic [31:0]        r_data_q [NUM_REQ];
  logic [7:0]         r_age    [NUM_REQ];
  logic [IW-1:0]      r_last;

  logic               w_found;
  logic [IW-1:0]      w_gnt_idx;
  logic [CW-1:0]      w_cand;
  logic               w_grant;
  logic [NUM_REQ-1:0] w_retire;
  logic               w_starve;

  assign w_grant        = !i_cpu_we && w_found;
  assign o_ext_ready    = ~r_pend;
  assign o_ext_ack      = r_ack;
  assign o_ext_overflow = r_ovf;
  assign o_starve       = w_starve;

  // Round-robin search: first pending writer upward from last+1, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = {1'b0, r_last} + CW'(k);
      if (w_cand >= NR_C) w_cand = w_cand - NR_C;
      if (!w_found && r_pend[w_cand[IW-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[IW-1:0];
      end
    end
  end

  // One-hot retire vector for the writer granted this cycle.
  always_comb begin
    w_retire = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_retire[i] = w_grant && (w_gnt_idx == IW'(i));
    end
  end

  // The write-port mux. The CPU passes straight through. A granted entry
  // targeting r0 still retires, but it must not assert the write enable.
  always_comb begin
    o_rf_we    = 1'b0;
    o_rf_waddr = '0;
    o_rf_wdata = '0;
    o_rf_src   = '0;
    if (i_cpu_we) begin
      o_rf_we    = 1'b1;
      o_rf_waddr = i_cpu_waddr;
      o_rf_wdata = i_cpu_wdata;
    end else if (w_found) begin
      o_rf_we    = (r_addr_q[w_gnt_idx] != 5'd0);
      o_rf_waddr = r_addr_q[w_gnt_idx];
      o_rf_wdata = r_data_q[w_gnt_idx];
      o_rf_src   = {{(3-IW){1'b0}}, w_gnt_idx} + 3'd1;
    end
  end

  // Starvation flag: any pending entry that has waited too long.
  always_comb begin
    w_starve = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_pend[i] && (r_age[i] >= SL_C)) w_starve = 1'b1;
    end
  end

  // Buffer state: accept, overflow, retire, ack pulse and ageing.
  // A request that arrives while the entry is still pending counts as an
  // overflow. This includes the edge where that entry retires.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pend <= '0;
      r_ack  <= '0;
      r_ovf  <= '0;
      r_last <= IW'(NUM_REQ - 1);
      for (int i = 0; i < NUM_REQ; i++) begin
        r_addr_q[i] <= '0;
        r_data_q[i] <= '0;
        r_age[i]    <= '0;
      end
    end else begin
      r_ack <= w_retire;
      if (w_grant) r_last <= w_gnt_idx;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_pend[i]) begin
          if (i_ext_req[i]) r_ovf[i] <= 1'b1;
          if (w_retire[i]) begin
            r_pend[i] <= 1'b0;
          end else if (r_age[i] != 8'hFF) begin
            r_age[i] <= r_age[i] + 8'd1;
          end
        end else if (i_ext_req[i]) begin
          r_pend[i]   <= 1'b1;
          r_addr_q[i] <= i_ext_addr[5*i +: 5];
          r_data_q[i] <= i_ext_data[32*i +: 32];
          r_age[i]    <= 8'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter.
// The stimulus process drives one cycle at a time. For each cycle it pushes
// the expected outputs, computed from a behavioural model of the arbitration
// rules. A negedge monitor pops those expectations and compares them with
// the DUT outputs.
module tb_regfile_write_arbiter;

  localparam int N  = 2;
  localparam int SL = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cpu_we = 1'b0;
  logic [4:0]      cpu_waddr = '0;
  logic [31:0]     cpu_wdata = '0;
  logic [N-1:0]    ext_req = '0;
  logic [5*N-1:0]  ext_addr = '0;
  logic [32*N-1:0] ext_data = '0;
  logic [N-1:0]    ext_ready, ext_ack, ext_overflow;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic [2:0]      rf_src;
  logic            starve;

  regfile_write_arbiter #(.NUM_REQ(N), .STARVE_LIMIT(SL)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_cpu_we(cpu_we), .i_cpu_waddr(cpu_waddr),
    .i_cpu_wdata(cpu_wdata), .i_ext_req(ext_req), .i_ext_addr(ext_addr),
    .i_ext_data(ext_data), .o_ext_ready(ext_ready), .o_ext_ack(ext_ack),
    .o_ext_overflow(ext_overflow), .o_rf_we(rf_we), .o_rf_waddr(rf_waddr),
    .o_rf_wdata(rf_wdata), .o_rf_src(rf_src), .o_starve(starve)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  src;
    logic [N-1:0] ready;
    logic [N-1:0] ack;
    logic [N-1:0] ovf;
    logic        starve;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Stimulus for the next cycle. Request strobes clear themselves after use.
  bit          s_rst = 1'b0;
  bit          s_cpu_we = 1'b0;
  logic [4:0]  s_cpu_waddr = '0;
  logic [31:0] s_cpu_wdata = '0;
  bit [N-1:0]  s_req = '0;
  logic [4:0]  s_addr [N];
  logic [31:0] s_data [N];

  // Reference model: one buffer slot per writer plus the last served writer.
  bit          m_pend [N];
  logic [4:0]  m_addr [N];
  logic [31:0] m_data [N];
  int          m_wait [N];
  bit          m_ack  [N];
  bit          m_ovf  [N];
  int          m_last;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_addr[i] = '0; m_data[i] = '0;
      m_wait[i] = 0; m_ack[i] = 0; m_ovf[i] = 0;
    end
    m_last = N - 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    exp_t e;
    int   g, best, d;
    @(posedge clk);
    #1;
    rst_n     = s_rst;
    cpu_we    = s_cpu_we;
    cpu_waddr = s_cpu_waddr;
    cpu_wdata = s_cpu_wdata;
    ext_req   = s_req;
    for (int i = 0; i < N; i++) begin
      ext_addr[5*i +: 5]   = s_addr[i];
      ext_data[32*i +: 32] = s_data[i];
    end
    if (!s_rst) model_reset();
    // Winner: the pending writer at the smallest rotational distance past the last one served.
    g = -1;
    best = N;
    if (!s_cpu_we) begin
      for (int i = 0; i < N; i++) begin
        d = (i - m_last - 1 + 2 * N) % N;
        if (m_pend[i] && d < best) begin
          best = d;
          g = i;
        end
      end
    end
    e = '{we: 1'b0, waddr: '0, wdata: '0, src: '0, ready: '0, ack: '0, ovf: '0, starve: 1'b0};
    if (s_cpu_we) begin
      e.we = 1'b1; e.waddr = s_cpu_waddr; e.wdata = s_cpu_wdata;
    end else if (g >= 0) begin
      e.we = (m_addr[g] != 5'd0); e.waddr = m_addr[g]; e.wdata = m_data[g];
      e.src = 3'(g + 1);
    end
    for (int i = 0; i < N; i++) begin
      e.ready[i] = !m_pend[i];
      e.ack[i]   = m_ack[i];
      e.ovf[i]   = m_ovf[i];
      if (m_pend[i] && ((m_wait[i] > 255 ? 255 : m_wait[i]) >= SL)) e.starve = 1'b1;
    end
    q.push_back(e);
    // Advance the model across the coming edge.
    if (s_rst) begin
      for (int i = 0; i < N; i++) begin
        m_ack[i] = (i == g);
        if (m_pend[i]) begin
          if (s_req[i]) m_ovf[i] = 1;
          if (i == g) m_pend[i] = 0;
          else m_wait[i]++;
        end else if (s_req[i]) begin
          m_pend[i] = 1; m_addr[i] = s_addr[i]; m_data[i] = s_data[i]; m_wait[i] = 0;
        end
      end
      if (g >= 0) m_last = g;
    end
    s_req = '0;
  endtask

  task automatic req(input int i, input logic [4:0] a, input logic [31:0] dt);
    s_req[i] = 1'b1;
    s_addr[i] = a;
    s_data[i] = dt;
  endtask

  task automatic cpu(input bit we, input logic [4:0] a, input logic [31:0] dt);
    s_cpu_we = we;
    s_cpu_waddr = a;
    s_cpu_wdata = dt;
  endtask

  // Monitor: every cycle presents a write-port decision. Check it against the queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("rf_we", 32'(rf_we), 32'(mon_e.we));
      chk("rf_waddr", 32'(rf_waddr), 32'(mon_e.waddr));
      chk("rf_wdata", rf_wdata, mon_e.wdata);
      chk("rf_src", 32'(rf_src), 32'(mon_e.src));
      chk("ext_ready", 32'(ext_ready), 32'(mon_e.ready));
      chk("ext_ack", 32'(ext_ack), 32'(mon_e.ack));
      chk("ext_overflow", 32'(ext_overflow), 32'(mon_e.ovf));
      chk("starve", 32'(starve), 32'(mon_e.starve));
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      s_addr[i] = '0;
      s_data[i] = '0;
    end
    model_reset();
    // Reset held, then released.
    s_rst = 0; cpu(1'b0, 5'd0, 32'd0);
    repeat (2) cycle();
    s_rst = 1;
    cycle();
    // Idle pass-through.
    cpu(1'b1, 5'd5, 32'hDEAD);
    cycle();
    // Score inject from writer 0.
    cpu(1'b0, 5'd0, 32'd0);
    req(0, 5'd30, 32'd7);
    repeat (4) cycle();
    // CPU priority with starvation.
    cpu(1'b1, 5'd12, 32'h1234);
    req(0, 5'd30, 32'd7);
    cycle();
    repeat (6) cycle();
    cpu(1'b0, 5'd0, 32'd0);
    repeat (3) cycle();
    // Overflow on writer 1: the first value is kept.
    cpu(1'b1, 5'd3, 32'h55);
    req(1, 5'd9, 32'hAAAA);
    cycle();
    req(1, 5'd9, 32'hBBBB);
    cycle();
    cpu(1'b0, 5'd0, 32'd0);
    repeat (3) cycle();
    // Round-robin: both writers request together, twice.
    req(0, 5'd10, 32'h100); req(1, 5'd11, 32'h101);
    cycle();
    repeat (2) cycle();
    req(0, 5'd10, 32'h200); req(1, 5'd11, 32'h201);
    cycle();
    repeat (3) cycle();
    // Register 0: the entry retires and acks, but no write enable.
    req(0, 5'd0, 32'hF00D);
    repeat (3) cycle();
    // Reset while an entry is pending.
    cpu(1'b1, 5'd1, 32'h1);
    req(0, 5'd4, 32'h44);
    cycle();
    cycle();
    s_rst = 0;
    repeat (2) cycle();
    s_rst = 1; cpu(1'b0, 5'd0, 32'd0);
    repeat (3) cycle();
    // Randomised traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      s_rst = ($urandom_range(0, 149) != 0);
      cpu($urandom_range(0, 99) < 50, 5'($urandom), $urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 99) < 35) req(i, 5'($urandom_range(0, 31)), $urandom);
      end
      cycle();
    end
    s_rst = 1;
    cycle();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
